// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from the 8-bit synchronous FIFO read port and
// serialises each one onto the UART line as an 8N1 frame (start bit, 8 data
// bits LSB first, stop bit). Shares the FIFO clock and synchronous reset.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rn,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // The read strobe follows fifo_empty combinationally while in FETCH so a
  // late-rising empty flag still suppresses the read in that same cycle.
  assign fifo_rn = (state_q == S_FETCH) && !fifo_empty;

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

  // Frame sequencer: next state, counters, shift register and registered
  // line/status outputs are all updated together so outputs track the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end

        S_FETCH: begin
          if (fifo_empty) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
          shift_q <= fifo_data;
          bit_q   <= '0;
          baud_q  <= '0;
          tx_q    <= 1'b0;
          state_q <= S_START;
        end

        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // shift_q[1] is the bit that becomes shift_q[0] after this edge.
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        S_STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT, every cycle
// of {tx, fifo_rn, busy, tx_done} is traced and compared against a frame
// model computed from the bit timing of an 8N1 frame.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset1, reset2, sel, hold_empty;
  logic [7:0] fifo_data;
  logic       fifo_empty_m;
  logic       e1, e2, rn1, rn2, tx1, tx2, busy1, busy2, done1, done2;

  // Only the selected DUT sees the FIFO; the other one sees a permanently empty FIFO.
  assign e1 = sel ? 1'b1 : fifo_empty_m;
  assign e2 = sel ? fifo_empty_m : 1'b1;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset1), .fifo_empty(e1), .fifo_data(fifo_data),
    .fifo_rn(rn1), .tx(tx1), .busy(busy1), .tx_done(done1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .reset(reset2), .fifo_empty(e2), .fifo_data(fifo_data),
    .fifo_rn(rn2), .tx(tx2), .busy(busy2), .tx_done(done2)
  );

  logic [7:0]  fq[$];    // FIFO contents
  logic [7:0]  sent[$];  // bytes expected on the line for the current trace
  logic [3:0]  tr[$];    // observed {tx, fifo_rn, busy, tx_done} per cycle
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cpb = 4;

  // Expected {tx, rn, busy, done} at cycle cyc, where cycle 0 is the first
  // idle cycle with data available and all of 'sent' is queued back-to-back.
  function automatic logic [3:0] exp_vec(input int unsigned cyc);
    int unsigned len;
    int unsigned n;
    int unsigned i;
    int unsigned r;
    int unsigned bitpos;
    logic [7:0]  b;
    len = 3 + 10 * cpb;
    n   = sent.size();
    i   = cyc / len;
    r   = cyc % len;
    if (i >= n) return (n > 0 && cyc == n * len) ? 4'b1001 : 4'b1000;
    if (r == 0) return (i > 0) ? 4'b1001 : 4'b1000;
    if (r == 1) return 4'b1110;
    if (r == 2) return 4'b1010;
    bitpos = (r - 3) / cpb;
    b = sent[i];
    if (bitpos == 0) return 4'b0010;
    if (bitpos == 9) return 4'b1010;
    return {b[bitpos-1], 3'b010};
  endfunction

  // One clock: sample outputs at the falling edge, then model the FIFO's
  // registered read port just after the rising edge.
  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = sel ? rn2 : rn1;
    tr.push_back(sel ? {tx2, rn2, busy2, done2} : {tx1, rn1, busy1, done1});
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty_m = hold_empty || (fq.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    sent.push_back(b);
    fifo_empty_m = hold_empty || (fq.size() == 0);
  endtask

  task automatic test_reset();
    reset1 = 1'b1;
    reset2 = 1'b1;
    tr.delete();
    tick();
    tick();
    checks++;
    if (tr[1] !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", tr[1], 4'b1000);
    end
    checks++;
    if ({tx2, rn2, busy2, done2} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state_c2 got=%b exp=%b", {tx2, rn2, busy2, done2}, 4'b1000);
    end
    reset1 = 1'b0;
    reset2 = 1'b0;
    tr.delete();
    repeat (100) tick();
    foreach (tr[k]) begin
      checks++;
      if (tr[k] !== 4'b1000) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d got=%b exp=%b", k, tr[k], 4'b1000);
      end
    end
  endtask

  task automatic test_single_byte();
    int unsigned nrn;
    sent.delete();
    tr.delete();
    push(8'hA5);
    repeat (43 + 6) tick();
    foreach (tr[k]) begin
      checks++;
      if (tr[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL single_trace cyc=%0d got=%b exp=%b", k, tr[k], exp_vec(k));
      end
    end
    checks++;
    if (tr[43] !== 4'b1001) begin
      errors++;
      $display("FAIL single_done43 got=%b exp=%b", tr[43], 4'b1001);
    end
    nrn = 0;
    foreach (tr[k]) if (tr[k][2]) nrn++;
    checks++;
    if (nrn !== 1) begin
      errors++;
      $display("FAIL single_rn_count got=%0d exp=1", nrn);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned nrn;
    int unsigned ndone;
    sent.delete();
    tr.delete();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    repeat (3 * 43 + 6) tick();
    foreach (tr[k]) begin
      checks++;
      if (tr[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL b2b_trace cyc=%0d got=%b exp=%b", k, tr[k], exp_vec(k));
      end
    end
    nrn = 0;
    ndone = 0;
    foreach (tr[k]) begin
      if (tr[k][2]) nrn++;
      if (tr[k][0]) ndone++;
    end
    checks++;
    if (nrn !== 3) begin
      errors++;
      $display("FAIL b2b_rn_count got=%0d exp=3", nrn);
    end
    checks++;
    if (ndone !== 3) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d exp=3", ndone);
    end
  endtask

  task automatic test_reset_mid_frame();
    sent.delete();
    tr.delete();
    push(8'h55);
    repeat (25) tick();
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    foreach (tr[k]) begin
      checks++;
      if (tr[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", k, tr[k], exp_vec(k));
      end
    end
    sent.delete();
    tr.delete();
    push(8'h96);
    repeat (43 + 6) tick();
    checks++;
    if (tr[0] !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_after got=%b exp=%b", tr[0], 4'b1000);
    end
    foreach (tr[k]) begin
      checks++;
      if (tr[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL midrst_next cyc=%0d got=%b exp=%b", k, tr[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_fetch_empty();
    sent.delete();
    tr.delete();
    push(8'hC3);
    tick();
    hold_empty   = 1'b1;
    fifo_empty_m = 1'b1;
    repeat (5) tick();
    checks++;
    if (tr[1] !== 4'b1010) begin
      errors++;
      $display("FAIL fetch_empty_rn got=%b exp=%b", tr[1], 4'b1010);
    end
    for (int k = 2; k < 6; k++) begin
      checks++;
      if (tr[k] !== 4'b1000) begin
        errors++;
        $display("FAIL fetch_empty_idle cyc=%0d got=%b exp=%b", k, tr[k], 4'b1000);
      end
    end
    hold_empty   = 1'b0;
    fifo_empty_m = (fq.size() == 0);
    tr.delete();
    repeat (43 + 6) tick();
    foreach (tr[k]) begin
      checks++;
      if (tr[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL fetch_empty_resume cyc=%0d got=%b exp=%b", k, tr[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_clks2();
    sel = 1'b1;
    cpb = 2;
    fifo_empty_m = (fq.size() == 0);
    sent.delete();
    tr.delete();
    push(8'h81);
    repeat (23 + 6) tick();
    foreach (tr[k]) begin
      checks++;
      if (tr[k] !== exp_vec(k)) begin
        errors++;
        $display("FAIL c2_trace cyc=%0d got=%b exp=%b", k, tr[k], exp_vec(k));
      end
    end
    checks++;
    if (tr[23] !== 4'b1001) begin
      errors++;
      $display("FAIL c2_done23 got=%b exp=%b", tr[23], 4'b1001);
    end
    sel = 1'b0;
    cpb = 4;
  endtask

  task automatic test_random();
    int unsigned n;
    for (int round = 0; round < 4; round++) begin
      repeat ($urandom_range(0, 5)) tick();
      sent.delete();
      tr.delete();
      n = $urandom_range(1, 4);
      for (int j = 0; j < int'(n); j++) push(8'($urandom));
      repeat (n * 43 + 6) tick();
      foreach (tr[k]) begin
        checks++;
        if (tr[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL rand_trace round=%0d cyc=%0d got=%b exp=%b", round, k, tr[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    sel          = 1'b0;
    hold_empty   = 1'b0;
    fifo_empty_m = 1'b1;
    fifo_data    = 8'h00;
    reset1       = 1'b1;
    reset2       = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_fetch_empty();
    test_clks2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's 8-bit synchronous FIFO. Drains bytes from the FIFO read port one at a time and serialises each onto a UART line as 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. It sits between the FIFO and the board TX pin and shares the FIFO's clock and reset.

## Interface

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit. Legal values are ≥ 2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  8  FIFO registered read data; valid the cycle after a read strobe
- fifo_rn  output  1  FIFO read strobe; one cycle per byte
- tx  output  1  serial line; idles high
- busy  output  1  high whenever state ≠ IDLE
- tx_done  output  1  one-cycle pulse after each stop bit completes

## Operation

- Reset is synchronous, active-high; clock is clk. On reset:
  - state = IDLE; baud and bit counters = 0; shift register = 0.
  - Outputs: tx=1, fifo_rn=0, busy=0, tx_done=0.
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: tx=1.
  - fifo_empty=0 → FETCH.
  - Otherwise stay in IDLE.
- FETCH: lasts 1 cycle.
  - fifo_rn = ~fifo_empty.
  - If fifo_empty=1 (defensive case), return to IDLE and issue no read.
  - Otherwise → LOAD.
- LOAD: lasts 1 cycle.
  - shift register ← fifo_data; bit counter ← 0.
  - → START.
- START: tx=0 for CLKS_PER_BIT cycles, then → DATA.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles.
  - Then shift right by 1 and increment the bit counter.
  - After bit 7 completes → STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then → IDLE, with tx_done=1 for that single cycle.
- Baud counter:
  - Width is max(1, clog2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - Resets to 0 on entry to START.
- Bit counter: 3 bits, 0..7. No wrap is used.
- This block is the only reader of the FIFO, so fifo_empty cannot rise between IDLE and FETCH except after a reset.
- fifo_rn is never asserted outside FETCH. This guarantees exactly one read per frame.
- Reset mid-frame:
  - The frame is aborted and tx=1 on the next cycle.
  - The in-flight byte is lost. No partial stop bit and no tx_done pulse are produced.
- Writes to the FIFO during a frame have no effect on the frame in progress.

## Timing

Cycle numbering: cycle 0 = first IDLE cycle in which fifo_empty=0. C = CLKS_PER_BIT.

- Cycle 1: FETCH, fifo_rn=1.
- Cycle 2: LOAD, fifo_data captured.
- Cycles 3 .. 3+C-1: tx=0 (start bit).
- Data bit k occupies cycles 3+C(k+1) .. 3+C(k+2)-1.
- Stop bit occupies cycles 3+9C .. 3+10C-1.
- Cycle 3+10C: IDLE, tx_done=1.
- Frame length: 10C cycles of line time plus a 3-cycle fetch overhead.
- Back-to-back bytes: the gap from the last stop-bit cycle to the next start bit is 3 extra high cycles (IDLE, FETCH, LOAD). tx stays 1 throughout.
- busy is 1 from cycle 1 through cycle 3+10C-1 and 0 at cycle 3+10C.

## Test plan

CLKS_PER_BIT=4 throughout; "line" values are listed one per 4-cycle bit.

1. Reset then idle with fifo_empty=1 held for 100 cycles → tx=1, fifo_rn=0, busy=0 and tx_done=0 for the whole window.
2. Single byte 0xA5 presented, fifo_empty dropping at cycle 0:
   - fifo_rn=1 only at cycle 1.
   - Line: 0,1,0,1,0,0,1,0,1,1.
   - tx_done pulses at cycle 43.
3. Three bytes 0x00, 0xFF, 0x3C queued:
   - Exactly 3 fifo_rn pulses.
   - Three correct frames: 0x3C is sent as 0,0,0,1,1,1,1,0,0,1.
   - 3 high cycles between each stop bit and the next start bit.
   - 3 tx_done pulses.
4. Reset asserted during data bit 4 of 0x55 → tx=1 the next cycle, state IDLE, no tx_done pulse. After release with fifo_empty=0, the next frame starts cleanly at FETCH.
5. fifo_empty forced to 1 while in FETCH (defensive case) → fifo_rn=0, return to IDLE, tx stays 1.
6. CLKS_PER_BIT=2, byte 0x81 → line 0,1,0,0,0,0,0,0,1,1 at 2 cycles per bit; tx_done at cycle 23.
